divider_seq_nr: RTL and testbench

Parametrised sequential non-restoring divider that computes one or more quotient bits per clock by iterating the add/subtract division row, replacing the fully unrolled array divider where area and compile time matter. It sits beside the ALU and serves the DIV instruction. It takes operands through a start/done handshake and returns quotient and remainder. It supports signed and unsigned modes and flags divide-by-zero.

---
 rtl/divider_seq_nr.sv | 141 ++++++++++++++
 tb/tb_divider_seq_nr.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_nr.sv
// Sequential non-restoring divider, ROWS_PER_CYCLE rows per clock.
// Ports: in_clk/in_rst_n, in_start/in_signed/in_dividend/in_divisor
// in; out_busy, out_done, out_quotient, out_remainder,
// out_div_by_zero out.
module divider_seq_nr #(
  parameter int WIDTH          = 32,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_start,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero
);

  localparam int N  = WIDTH / ROWS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_t;

  state_t state, state_nx;

  logic [WIDTH:0]   p, p_nx, sh, d_ext;
  logic [WIDTH-1:0] q, q_nx, d;
  logic [CW-1:0]    cnt;
  logic             sa, sb, dz;

  logic             accept, dz_in;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] r_mag, q_fin, r_fin;

  // a start in the done cycle is dropped
  assign accept = (state == IDLE) && in_start && !out_done;
  assign dz_in  = (in_divisor == '0);
  assign a_neg  = in_signed & in_dividend[WIDTH-1];
  assign b_neg  = in_signed & in_divisor[WIDTH-1];
  assign a_mag  = a_neg ? -in_dividend : in_dividend;
  assign b_mag  = b_neg ? -in_divisor : in_divisor;
  assign d_ext  = {1'b0, d};
  assign out_busy = (state != IDLE);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = ITER;
      ITER: if (cnt == CW'(1)) state_nx = FIX;
      FIX:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // chained rows; P wraps modulo 2^(WIDTH+1) but
  // always lands back in [-D, D), so its sign is exact
  always_comb begin
    p_nx = p;
    q_nx = q;
    sh   = '0;
    for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
      sh = {p_nx[WIDTH-1:0], q_nx[WIDTH-1]};
      if (!p_nx[WIDTH]) sh = sh - d_ext;
      else              sh = sh + d_ext;
      q_nx = {q_nx[WIDTH-2:0], ~sh[WIDTH]};
      p_nx = sh;
    end
  end

  // restored remainder lies in [0, D), so WIDTH bits suffice
  assign r_mag = p[WIDTH] ? (p[WIDTH-1:0] + d)
                          : p[WIDTH-1:0];
  assign q_fin = (sa ^ sb) ? -q : q;
  assign r_fin = sa ? -r_mag : r_mag;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      p               <= '0;
      q               <= '0;
      d               <= '0;
      cnt             <= '0;
      sa              <= 1'b0;
      sb              <= 1'b0;
      dz              <= 1'b0;
      out_done        <= 1'b0;
      out_quotient    <= '0;
      out_remainder   <= '0;
      out_div_by_zero <= 1'b0;
    end else begin
      out_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            p  <= '0;
            // zero divisor keeps the raw dividend in Q
            q  <= dz_in ? in_dividend : a_mag;
            d  <= b_mag;
            sa <= a_neg;
            sb <= b_neg;
            dz <= dz_in;
            // zero divisor: one idle ITER cycle, then FIX
            cnt <= dz_in ? CW'(1) : CW'(N);
          end
        end
        ITER: begin
          cnt <= cnt - CW'(1);
          if (!dz) begin
            p <= p_nx;
            q <= q_nx;
          end
        end
        FIX: begin
          out_done        <= 1'b1;
          out_div_by_zero <= dz;
          if (dz) begin
            out_quotient  <= '1;
            out_remainder <= q;
          end else begin
            out_quotient  <= q_fin;
            out_remainder <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq_nr.sv
// Directed bench for divider_seq_nr: three instances
// (32/1, 32/4, 8/2) checked against hand-computed results.
module tb_divider_seq_nr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       start, sgn, busy, done, dz;
  logic [1:0][31:0] a, b;
  logic [7:0]       a8, b8, q8, r8;
  logic [31:0]      qo [3];
  logic [31:0]      ro [3];
  logic [31:0]      q32 [2];
  logic [31:0]      r32 [2];

  always_comb begin
    qo[0] = q32[0];
    qo[1] = q32[1];
    qo[2] = {24'h0, q8};
    ro[0] = r32[0];
    ro[1] = r32[1];
    ro[2] = {24'h0, r8};
  end

  int cmp = 0;
  int bad = 0;

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  divider_seq_nr #(.WIDTH(32), .ROWS_PER_CYCLE(1)) u0 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start[0]),
    .in_signed(sgn[0]), .in_dividend(a[0]), .in_divisor(b[0]),
    .out_busy(busy[0]), .out_done(done[0]),
    .out_quotient(q32[0]), .out_remainder(r32[0]),
    .out_div_by_zero(dz[0]));

  divider_seq_nr #(.WIDTH(32), .ROWS_PER_CYCLE(4)) u1 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start[1]),
    .in_signed(sgn[1]), .in_dividend(a[1]), .in_divisor(b[1]),
    .out_busy(busy[1]), .out_done(done[1]),
    .out_quotient(q32[1]), .out_remainder(r32[1]),
    .out_div_by_zero(dz[1]));

  divider_seq_nr #(.WIDTH(8), .ROWS_PER_CYCLE(2)) u2 (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start[2]),
    .in_signed(sgn[2]), .in_dividend(a8), .in_divisor(b8),
    .out_busy(busy[2]), .out_done(done[2]),
    .out_quotient(q8), .out_remainder(r8),
    .out_div_by_zero(dz[2]));

  task automatic set_ops(input int u, input logic [31:0] av,
                         input logic [31:0] bv);
    if (u == 2) begin
      a8 = av[7:0];
      b8 = bv[7:0];
    end else begin
      a[u] = av;
      b[u] = bv;
    end
  endtask

  // one division; operands are scrambled right after capture
  task automatic do_div(input int u, input vec_t v,
                        output logic [31:0] qv,
                        output logic [31:0] rv,
                        output logic zv, output int lat,
                        output int bc, output logic pulse_ok);
    @(negedge clk);
    start[u] = 1'b1;
    sgn[u]   = v.s;
    set_ops(u, v.a, v.b);
    @(posedge clk);
    #1;
    start[u] = 1'b0;
    sgn[u]   = ~v.s;
    set_ops(u, ~v.a, v.a);
    lat = 0;
    bc  = 0;
    while (done[u] !== 1'b1 && lat < 100) begin
      if (busy[u] === 1'b1) bc++;
      @(posedge clk);
      #1;
      lat++;
    end
    qv = qo[u];
    rv = ro[u];
    zv = dz[u];
    @(posedge clk);
    #1;
    pulse_ok = (done[u] === 1'b0);
  endtask

  task automatic run_table(input int u, input string nm,
                           input vec_t tv[$]);
    logic [31:0] qv, rv;
    logic        zv, pk;
    int          lat, bc;
    foreach (tv[i]) begin
      do_div(u, tv[i], qv, rv, zv, lat, bc, pk);
      cmp++;
      if (qv !== tv[i].q) begin
        bad++;
        $display("FAIL %s[%0d] quotient: got %h want %h",
                 nm, i, qv, tv[i].q);
      end
      cmp++;
      if (rv !== tv[i].r) begin
        bad++;
        $display("FAIL %s[%0d] remainder: got %h want %h",
                 nm, i, rv, tv[i].r);
      end
      cmp++;
      if (zv !== tv[i].z) begin
        bad++;
        $display("FAIL %s[%0d] div_by_zero: got %b want %b",
                 nm, i, zv, tv[i].z);
      end
      cmp++;
      if (lat != tv[i].lat) begin
        bad++;
        $display("FAIL %s[%0d] latency: got %0d want %0d",
                 nm, i, lat, tv[i].lat);
      end
      cmp++;
      if (bc != tv[i].lat) begin
        bad++;
        $display("FAIL %s[%0d] busy cycles: got %0d want %0d",
                 nm, i, bc, tv[i].lat);
      end
      cmp++;
      if (pk !== 1'b1) begin
        bad++;
        $display("FAIL %s[%0d] done pulse: got %b want 1",
                 nm, i, ~pk);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      cmp++;
      if ({busy[u], done[u], dz[u]} !== 3'b000 ||
          qo[u] !== 32'h0 || ro[u] !== 32'h0) begin
        bad++;
        $display("FAIL reset u%0d: got b%b d%b z%b q%h r%h want 0",
                 u, busy[u], done[u], dz[u], qo[u], ro[u]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    vec_t t[$];
    t.push_back('{1'b0, 32'd12, 32'd7, 32'd1, 32'd5, 1'b0, 33});
    t.push_back('{1'b0, 32'h80000000, 32'd3,
                  32'h2AAAAAAA, 32'd2, 1'b0, 33});
    t.push_back('{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE,
                  32'd1, 32'd1, 1'b0, 33});
    t.push_back('{1'b0, 32'hFFFFFFFF, 32'd1,
                  32'hFFFFFFFF, 32'd0, 1'b0, 33});
    run_table(0, "unsigned", t);
  endtask

  task automatic test_signed();
    vec_t t[$];
    t.push_back('{1'b1, 32'hFFFFFFF9, 32'd2,
                  32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33});
    t.push_back('{1'b1, 32'd7, 32'hFFFFFFFE,
                  32'hFFFFFFFD, 32'd1, 1'b0, 33});
    t.push_back('{1'b1, 32'hFFFFFF9C, 32'd7,
                  32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33});
    t.push_back('{1'b1, 32'h80000000, 32'hFFFFFFFF,
                  32'h80000000, 32'd0, 1'b0, 33});
    run_table(0, "signed", t);
  endtask

  task automatic test_div_by_zero();
    vec_t t[$];
    t.push_back('{1'b0, 32'h1234, 32'd0,
                  32'hFFFFFFFF, 32'h1234, 1'b1, 2});
    t.push_back('{1'b1, 32'hFFFFFFFB, 32'd0,
                  32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 2});
    run_table(0, "div0", t);
  endtask

  task automatic test_ignore_busy();
    int lat;
    @(negedge clk);
    start[0] = 1'b1;
    sgn[0]   = 1'b0;
    set_ops(0, 32'd100, 32'd7);
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    lat = 0;
    while (done[0] !== 1'b1 && lat < 100) begin
      if (lat == 5) begin
        start[0] = 1'b1;
        set_ops(0, 32'd50, 32'd5);
      end
      if (lat == 7) start[0] = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    cmp++;
    if (qo[0] !== 32'd14 || ro[0] !== 32'd2) begin
      bad++;
      $display("FAIL ignore_busy result: got q%h r%h want q0e r02",
               qo[0], ro[0]);
    end
    cmp++;
    if (lat != 33) begin
      bad++;
      $display("FAIL ignore_busy latency: got %0d want 33", lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    start[0] = 1'b1;
    sgn[0]   = 1'b0;
    set_ops(0, 32'd1000, 32'd3);
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp++;
    if ({busy[0], done[0], dz[0]} !== 3'b000 ||
        qo[0] !== 32'h0 || ro[0] !== 32'h0) begin
      bad++;
      $display("FAIL reset_abort: got b%b q%h r%h want 0",
               busy[0], qo[0], ro[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done[0] === 1'b1) seen = 1'b1;
    end
    cmp++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort done: got %b want 0", seen);
    end
  endtask

  task automatic test_rows4();
    vec_t t[$];
    t.push_back('{1'b0, 32'd1000, 32'd7,
                  32'd142, 32'd6, 1'b0, 9});
    t.push_back('{1'b1, 32'hFFFFFC18, 32'd7,
                  32'hFFFFFF72, 32'hFFFFFFFA, 1'b0, 9});
    t.push_back('{1'b0, 32'hDEADBEEF, 32'h10,
                  32'h0DEADBEE, 32'hF, 1'b0, 9});
    run_table(1, "rows4", t);
  endtask

  task automatic test_width8();
    vec_t t[$];
    t.push_back('{1'b0, 32'hC8, 32'h09, 32'h16, 32'h02, 1'b0, 5});
    t.push_back('{1'b1, 32'h80, 32'hFF, 32'h80, 32'h00, 1'b0, 5});
    t.push_back('{1'b1, 32'h64, 32'hF9, 32'hF2, 32'h02, 1'b0, 5});
    t.push_back('{1'b1, 32'h80, 32'h00, 32'hFF, 32'h80, 1'b1, 2});
    run_table(2, "w8r2", t);
  endtask

  initial begin
    start = '0;
    sgn   = '0;
    a     = '0;
    b     = '0;
    a8    = '0;
    b8    = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_ignore_busy();
    test_reset_abort();
    test_rows4();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==",
             cmp, bad);
    $finish;
  end

endmodule
